// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel coordinates, line/frame timing and lock status
// from a VGA sync/blank stream in the pixel-clock domain.
// Ports: Clock, Reset (async, active-high); hSync_n, vSync_n, blank_n in;
//   pixelX, pixelY, pixelValid, lineLength, frameLines, locked, lockLossCount out.
// Optional: `define VGA_SYNC_DECODER_STATS_EN adds the saturating lock-loss counter;
//   otherwise lockLossCount is tied to 0.
module vga_sync_decoder #(
  parameter int H_TOTAL     = 1040,
  parameter int V_TOTAL     = 666,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        hSync_n,
  input  logic        vSync_n,
  input  logic        blank_n,
  output logic [11:0] pixelX,
  output logic [11:0] pixelY,
  output logic        pixelValid,
  output logic [11:0] lineLength,
  output logic [11:0] frameLines,
  output logic        locked,
  output logic [7:0]  lockLossCount
);

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    LOCKED
  } state_t;

  localparam logic [11:0] H_T = 12'(H_TOTAL);
  localparam logic [11:0] V_T = 12'(V_TOTAL);
  localparam logic [3:0]  L_F = 4'(LOCK_FRAMES);

  logic        hs_q, vs_q, bl_q;
  logic        hFall, vFall, blRise, blFall;
  logic [11:0] hCnt, lCnt;
  logic [11:0] hLen, fLines;
  logic        hSeen, sat, checked, badLine, frameOk;
  state_t      state_q, state_d;
  logic [3:0]  goodCnt_q, goodCnt_d;
  logic        errFrame_q, errFrame_d;

  assign hFall  = hs_q & ~hSync_n;
  assign vFall  = vs_q & ~vSync_n;
  assign blRise = ~bl_q & blank_n;
  assign blFall = bl_q & ~blank_n;

  // hLen is the period closing on this hFall.
  // An hFall coincident with vFall still counts toward the closing frame.
  assign hLen    = hCnt + 12'd1;
  assign fLines  = lCnt + {11'd0, hFall};
  assign sat     = (hCnt == 12'hFFF);
  assign checked = hFall & hSeen;
  assign badLine = checked & (hLen != H_T);
  assign frameOk = ~errFrame_q & ~badLine & (fLines == V_T);
  assign locked  = (state_q == LOCKED);

  // Idle values match an undriven blanked link so reset makes no edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      bl_q <= 1'b0;
    end else begin
      hs_q <= hSync_n;
      vs_q <= vSync_n;
      bl_q <= blank_n;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hCnt       <= 12'd0;
      lineLength <= 12'd0;
      hSeen      <= 1'b0;
      lCnt       <= 12'd0;
      frameLines <= 12'd0;
    end else begin
      if (hFall) begin
        lineLength <= hLen;
        hCnt       <= 12'd0;
      end else if (!sat) begin
        hCnt <= hLen;
      end

      // Saturation is the only way into SEARCH, so it also rearms hSeen.
      if (sat) begin
        hSeen <= 1'b0;
      end else if (hFall) begin
        hSeen <= 1'b1;
      end

      if (vFall) begin
        frameLines <= fLines;
        lCnt       <= 12'd0;
      end else if (hFall) begin
        lCnt <= lCnt + 12'd1;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pixelValid <= 1'b0;
      pixelX     <= 12'd0;
      pixelY     <= 12'd0;
    end else begin
      pixelValid <= blank_n;

      if (blRise) begin
        pixelX <= 12'd0;
      end else if (blank_n) begin
        pixelX <= pixelX + 12'd1;
      end

      if (vFall) begin
        pixelY <= 12'd0;
      end else if (blFall) begin
        pixelY <= pixelY + 12'd1;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= SEARCH;
      goodCnt_q  <= 4'd0;
      errFrame_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      goodCnt_q  <= goodCnt_d;
      errFrame_q <= errFrame_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    goodCnt_d  = goodCnt_q;
    errFrame_d = errFrame_q;

    unique case (state_q)
      SEARCH: begin
        if (vFall) begin
          state_d    = MEASURE;
          goodCnt_d  = 4'd0;
          errFrame_d = 1'b0;
        end
      end
      MEASURE: begin
        errFrame_d = errFrame_q | badLine;
        if (vFall) begin
          errFrame_d = 1'b0;
          if (frameOk) begin
            if (goodCnt_q + 4'd1 == L_F) begin
              state_d   = LOCKED;
              goodCnt_d = 4'd0;
            end else begin
              goodCnt_d = goodCnt_q + 4'd1;
            end
          end else begin
            goodCnt_d = 4'd0;
          end
        end
      end
      LOCKED: begin
        // A bad line taints the rest of its frame, so that
        // frame cannot count toward relock.
        errFrame_d = vFall ? 1'b0 : (errFrame_q | badLine);
        if (badLine || (vFall && fLines != V_T)) begin
          state_d   = MEASURE;
          goodCnt_d = 4'd0;
        end
      end
      default: begin
        state_d = SEARCH;
      end
    endcase

    if (sat) begin
      state_d    = SEARCH;
      goodCnt_d  = 4'd0;
      errFrame_d = 1'b0;
    end
  end

`ifdef VGA_SYNC_DECODER_STATS_EN
  logic lossEvent;

  assign lossEvent = (state_q == LOCKED) && (state_d != LOCKED);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      lockLossCount <= 8'd0;
    end else if (lossEvent && lockLossCount != 8'hFF) begin
      lockLossCount <= lockLossCount + 8'd1;
    end
  end
`else
  assign lockLossCount = 8'd0;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: self-checking bench for vga_sync_decoder.
// Uses a reduced raster so every scenario fits a short run.
module tb_vga_sync_decoder;

  localparam int H   = 72;
  localparam int HV  = 56;
  localparam int HS0 = 60;
  localparam int HS1 = 67;
  localparam int V   = 62;
  localparam int VV  = 48;
  localparam int VS0 = 59;
  localparam int VS1 = 60;
  localparam int LF  = 2;
  localparam int FRAME_BUDGET = 2 * H * V;

  logic        Clock;
  logic        Reset;
  logic        hSync_n;
  logic        vSync_n;
  logic        blank_n;
  logic [11:0] pixelX;
  logic [11:0] pixelY;
  logic        pixelValid;
  logic [11:0] lineLength;
  logic [11:0] frameLines;
  logic        locked;
  logic [7:0]  lockLossCount;

  vga_sync_decoder #(
    .H_TOTAL    (H),
    .V_TOTAL    (V),
    .LOCK_FRAMES(LF)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .hSync_n      (hSync_n),
    .vSync_n      (vSync_n),
    .blank_n      (blank_n),
    .pixelX       (pixelX),
    .pixelY       (pixelY),
    .pixelValid   (pixelValid),
    .lineLength   (lineLength),
    .frameLines   (frameLines),
    .locked       (locked),
    .lockLossCount(lockLossCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  int h = 0;
  int v = 0;
  bit hmask = 0;
  bit coinc = 0;
  bit short_pend = 0;
  bit sb_on = 0;
  bit hs_prev = 1;
  bit vs_prev = 1;
  bit ev_h = 0;
  bit ev_v = 0;
  int since_h = 0;
  int exp_loss = 0;
  logic prev_locked;

  logic [23:0] sbq[$];
  int pix_cnt = 0;
  int pix_bad = 0;
  bit got_first = 0;
  logic [23:0] pix_first;
  logic [23:0] pix_last;

  // One pixel-clock of generator output; expected coordinates go to the
  // scoreboard as the visible cycle is driven.
  task automatic step();
    bit hs;
    bit vs;
    bit bl;
    int len;
    logic [23:0] e;
    hs = !(h >= HS0 && h <= HS1) || hmask;
    if (coinc)
      vs = !((v == VS0 && h >= HS0) || (v > VS0 && v <= VS1) ||
             (v == VS1 + 1 && h < HS0));
    else
      vs = !(v >= VS0 && v <= VS1);
    bl = (h < HV) && (v < VV);
    ev_h = hs_prev && !hs;
    ev_v = vs_prev && !vs;
    hSync_n = hs;
    vSync_n = vs;
    blank_n = bl;
    if (bl && sb_on) sbq.push_back({12'(h), 12'(v)});
    prev_locked = locked;
    @(posedge Clock);
    #1;
    if (pixelValid && sb_on) begin
      if (!got_first) begin
        pix_first = {pixelX, pixelY};
        got_first = 1;
      end
      pix_last = {pixelX, pixelY};
      pix_cnt++;
      if (sbq.size() == 0) begin
        pix_bad++;
      end else begin
        e = sbq.pop_front();
        if ({pixelX, pixelY} !== e) pix_bad++;
      end
    end
    hs_prev = hs;
    vs_prev = vs;
    since_h = ev_h ? 0 : since_h + 1;
    len = short_pend ? H - 1 : H;
    h++;
    if (h >= len) begin
      h = 0;
      short_pend = 0;
      v++;
      if (v == V) v = 0;
    end
  endtask

  task automatic gen_restart();
    h = 0;
    v = 0;
    hs_prev = 1;
    vs_prev = 1;
    hmask = 0;
    short_pend = 0;
    since_h = 0;
    exp_loss = 0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    hSync_n = 1'b1;
    vSync_n = 1'b1;
    blank_n = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    Reset = 1'b0;
    gen_restart();
  endtask

  task automatic run_vfalls(input int n, input string tag);
    int seen;
    int cyc;
    seen = 0;
    cyc = 0;
    while (seen < n && cyc < n * FRAME_BUDGET) begin
      step();
      cyc++;
      if (ev_v) seen++;
    end
    if (seen < n) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: saw %0d vfalls, required %0d", tag, seen, n);
    end
  endtask

  task automatic run_to(input int line, input int col, input string tag);
    int cyc;
    cyc = 0;
    while (!(v == line && h == col) && cyc < FRAME_BUDGET) begin
      step();
      cyc++;
    end
    if (!(v == line && h == col)) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: at line %0d col %0d, required %0d %0d",
               tag, v, h, line, col);
    end
  endtask

  task automatic check_relock(input string tag);
    run_vfalls(2, tag);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL %s_early: locked %b, required 0", tag, locked);
    end
    run_vfalls(1, tag);
    checks++;
    if (prev_locked !== 1'b0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL %s_lock: before/after %b/%b, required 0/1",
               tag, prev_locked, locked);
    end
    checks++;
    if (frameLines !== 12'(V) || lineLength !== 12'(H)) begin
      errors++;
      $display("FAIL %s_timing: lines %0d len %0d, required %0d %0d",
               tag, frameLines, lineLength, V, H);
    end
  endtask

  task automatic check_loss(input string tag);
`ifdef VGA_SYNC_DECODER_STATS_EN
    exp_loss++;
`endif
    checks++;
    if (lockLossCount !== 8'(exp_loss)) begin
      errors++;
      $display("FAIL %s_losscnt: got %0d, required %0d",
               tag, lockLossCount, exp_loss);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    hSync_n = 1'b1;
    vSync_n = 1'b1;
    blank_n = 1'b0;
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if ({pixelX, pixelY, pixelValid, lineLength, frameLines,
         locked, lockLossCount} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: x %0d y %0d v %b len %0d lines %0d lk %b loss %0d, required all 0",
               pixelX, pixelY, pixelValid, lineLength, frameLines,
               locked, lockLossCount);
    end
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
    gen_restart();
  endtask

  task automatic test_nominal();
    coinc = 0;
    check_relock("nominal");
    checks++;
    if (lockLossCount !== 8'd0) begin
      errors++;
      $display("FAIL nominal_losscnt: got %0d, required 0", lockLossCount);
    end
  endtask

  task automatic test_coords();
    sbq.delete();
    pix_cnt = 0;
    pix_bad = 0;
    got_first = 0;
    sb_on = 1;
    run_vfalls(1, "coords");
    sb_on = 0;
    checks++;
    if (pix_cnt !== HV * VV) begin
      errors++;
      $display("FAIL coords_count: got %0d, required %0d", pix_cnt, HV * VV);
    end
    checks++;
    if (pix_bad !== 0 || sbq.size() !== 0) begin
      errors++;
      $display("FAIL coords_scoreboard: bad %0d left %0d, required 0 0",
               pix_bad, sbq.size());
    end
    checks++;
    if (pix_first !== 24'd0) begin
      errors++;
      $display("FAIL coords_first: got %0d,%0d, required 0,0",
               pix_first[23:12], pix_first[11:0]);
    end
    checks++;
    if (pix_last !== {12'(HV - 1), 12'(VV - 1)}) begin
      errors++;
      $display("FAIL coords_last: got %0d,%0d, required %0d,%0d",
               pix_last[23:12], pix_last[11:0], HV - 1, VV - 1);
    end
  endtask

  task automatic test_short_line();
    int seen;
    int cyc;
    run_to(5, 0, "short");
    short_pend = 1;
    seen = 0;
    cyc = 0;
    while (seen < 2 && cyc < 4 * H) begin
      step();
      cyc++;
      if (ev_h) seen++;
    end
    checks++;
    if (seen < 2 || prev_locked !== 1'b1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL short_drop: hfalls %0d before/after %b/%b, required 2 1/0",
               seen, prev_locked, locked);
    end
    checks++;
    if (lineLength !== 12'(H - 1)) begin
      errors++;
      $display("FAIL short_len: got %0d, required %0d", lineLength, H - 1);
    end
    check_loss("short");
    check_relock("short_relock");
  endtask

  task automatic test_sync_loss();
    run_to(0, 0, "sync");
    hmask = 1;
    for (int i = 0; i < 58 * H; i++) begin
      step();
      if (since_h == 4095) begin
        checks++;
        if (locked !== 1'b1) begin
          errors++;
          $display("FAIL sync_before_sat: locked %b, required 1", locked);
        end
      end
      if (since_h == 4096) begin
        checks++;
        if (locked !== 1'b0) begin
          errors++;
          $display("FAIL sync_after_sat: locked %b, required 0", locked);
        end
      end
    end
    hmask = 0;
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL sync_lost: locked %b, required 0", locked);
    end
    check_loss("sync");
    check_relock("sync_relock");
  endtask

  task automatic test_coincident();
    do_reset();
    coinc = 1;
    check_relock("coinc");
  endtask

  task automatic test_reset_midframe();
    run_to(30, 20, "midreset");
    checks++;
    if (locked !== 1'b1 || pixelY !== 12'd30 || pixelX !== 12'd19) begin
      errors++;
      $display("FAIL midreset_pre: lk %b x %0d y %0d, required 1 19 30",
               locked, pixelX, pixelY);
    end
    #3;
    Reset = 1'b1;
    #1;
    checks++;
    if ({pixelX, pixelY, pixelValid, lineLength, frameLines,
         locked, lockLossCount} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: x %0d y %0d v %b len %0d lines %0d lk %b loss %0d, required all 0",
               pixelX, pixelY, pixelValid, lineLength, frameLines,
               locked, lockLossCount);
    end
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    run_vfalls(2, "midreset");
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL midreset_search: locked %b, required 0", locked);
    end
    checks++;
    if (frameLines !== 12'(V) || lineLength !== 12'(H)) begin
      errors++;
      $display("FAIL midreset_timing: lines %0d len %0d, required %0d %0d",
               frameLines, lineLength, V, H);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_coords();
    test_short_line();
    test_sync_loss();
    test_coincident();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
